// File: rtl/booth_pkg.sv
// +----------------------------------------------------------------------+
// | booth_pkg: shared types and constants for the Booth multiplier       |
// | sequencer. Rev 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package booth_pkg;

  localparam int DEFAULT_N = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_CAPT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    BUSY = ST_BUSY,
    CAPT = ST_CAPT
  } state_e;

  typedef struct packed {
    logic signed [DEFAULT_N-1:0] a;
    logic signed [DEFAULT_N-1:0] b;
  } operand_pair_t;

endpackage

`default_nettype wire

// File: rtl/operand_fifo2.sv
// +----------------------------------------------------------------------+
// | operand_fifo2: 2-deep synchronous FIFO holding operand pairs.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module operand_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/booth_mult_sequencer.sv
// +----------------------------------------------------------------------+
// | booth_mult_sequencer: streams operand pairs into the sequential      |
// | Booth core and returns products on a valid/ready port. Rev 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module booth_mult_sequencer
  import booth_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [N-1:0]   in_a,
  input  logic signed [N-1:0]   in_b,
  output logic                  mult_rst,
  output logic                  mult_load,
  output logic signed [N-1:0]   mult_a,
  output logic signed [N-1:0]   mult_b,
  input  logic [2*N-1:0]        mult_prod,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*N-1:0]        out_prod,
  output logic                  busy
);

  state_e         state;
  state_e         state_nx;
  logic [CW-1:0]  count;
  logic [2*N-1:0] head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           capt_go;
  logic           more_work;

  // in_ready is gated by the reset pin so nothing is accepted while held in reset
  assign in_ready  = rst & ~fifo_full;
  assign push      = in_valid & in_ready;
  assign more_work = ~fifo_empty | push;
  assign capt_go   = (state == CAPT) && (!out_valid || out_ready);

  operand_fifo2 #(
    .W (2*N)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({in_a, in_b}),
    .pop       (state == LOAD),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign mult_load = (state == LOAD);
  assign mult_a    = (state == LOAD) ? head[2*N-1:N] : '0;
  assign mult_b    = (state == LOAD) ? head[N-1:0]   : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (more_work) state_nx = LOAD;
      LOAD:    state_nx = BUSY;
      BUSY:    if (count == CW'(N-1)) state_nx = CAPT;
      CAPT:    if (capt_go) state_nx = more_work ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      mult_rst  <= 1'b1;
      out_valid <= 1'b0;
      out_prod  <= '0;
    end else begin
      state    <= state_nx;
      mult_rst <= 1'b0;
      if (state == LOAD) begin
        count <= '0;
      end else if (state == BUSY) begin
        count <= count + CW'(1);
      end
      // A fresh capture takes priority over the consumer draining the register
      if (capt_go) begin
        out_prod  <= mult_prod;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
